rs_age_param: RTL and testbench

- Parametrised reservation station; successor to the fixed 3-way RS.
- Sits between dispatch (rename/ROB allocation) and issue to the functional units. Holds renamed instructions until both source tags are ready.
- Issues up to ISSUE_W instructions per cycle in oldest-first order, limited per FU class.
- Additions over the fixed RS: age-matrix priority, per-class issue budgets, same-cycle CDB capture for dispatching instructions, a free-count output, and a full flush.

---
 rtl/rs_age_param.sv | 217 +++++++++++++++++++++
 tb/tb_rs_age_param.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_param.sv
// Reservation station: holds renamed ops until both sources are ready, issues oldest-first through an age matrix.
// Latency: a dispatched op is eligible the cycle after dispatch; wakeup to issue is 0 cycles (issue is combinational).
// Backpressure: disp_stall (all-or-nothing) whenever registered free_cnt < DISP_W; fu_budget throttles each FU class.
module rs_age_param #(
    parameter int N_ENTRIES = 16,
    parameter int DISP_W    = 3,
    parameter int ISSUE_W   = 3,
    parameter int CDB_W     = 3,
    parameter int TAG_W     = 6,
    parameter int N_CLASS   = 3,
    parameter int BUD_W     = 2,
    parameter int PAYLOAD_W = 96
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic [DISP_W-1:0]                    disp_valid,
    input  logic [DISP_W*TAG_W-1:0]              disp_tag1,
    input  logic [DISP_W*TAG_W-1:0]              disp_tag2,
    input  logic [DISP_W-1:0]                    disp_rdy1,
    input  logic [DISP_W-1:0]                    disp_rdy2,
    input  logic [DISP_W*$clog2(N_CLASS)-1:0]    disp_class,
    input  logic [DISP_W*PAYLOAD_W-1:0]          disp_payload,
    output logic                                 disp_stall,
    output logic [$clog2(N_ENTRIES+1)-1:0]       free_cnt,
    input  logic [CDB_W-1:0]                     cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]               cdb_tag,
    input  logic [N_CLASS*BUD_W-1:0]             fu_budget,
    output logic [ISSUE_W-1:0]                   issue_valid,
    output logic [ISSUE_W*$clog2(N_CLASS)-1:0]   issue_class,
    output logic [ISSUE_W*PAYLOAD_W-1:0]         issue_payload
);
    localparam int CLS_W = $clog2(N_CLASS);
    localparam int CNT_W = $clog2(N_ENTRIES + 1);
    localparam int ISS_W = $clog2(ISSUE_W + 1);
    localparam int DSP_W = $clog2(DISP_W + 1);

    logic [N_ENTRIES-1:0] valid_q, valid_d;
    logic [N_ENTRIES-1:0] rdy1_q, rdy1_d;
    logic [N_ENTRIES-1:0] rdy2_q, rdy2_d;
    logic [TAG_W-1:0]     tag1_q [N_ENTRIES];
    logic [TAG_W-1:0]     tag1_d [N_ENTRIES];
    logic [TAG_W-1:0]     tag2_q [N_ENTRIES];
    logic [TAG_W-1:0]     tag2_d [N_ENTRIES];
    logic [CLS_W-1:0]     cls_q  [N_ENTRIES];
    logic [CLS_W-1:0]     cls_d  [N_ENTRIES];
    logic [PAYLOAD_W-1:0] pay_q  [N_ENTRIES];
    logic [PAYLOAD_W-1:0] pay_d  [N_ENTRIES];
    logic [N_ENTRIES-1:0] older_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] older_d [N_ENTRIES];
    logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;

    logic [N_ENTRIES-1:0] wake1, wake2, elig, gnt, taken;
    logic [DISP_W-1:0]    dwake1, dwake2;
    logic [CNT_W-1:0]     rank [N_ENTRIES];
    logic [N_ENTRIES-1:0] lane_mask [DISP_W];
    logic [N_ENTRIES-1:0] prior;
    logic [BUD_W:0]       cls_used [N_CLASS];
    logic [ISS_W-1:0]     iss_cnt;
    logic [DSP_W-1:0]     alloc_cnt;
    logic                 disp_ok, found, bud_ok;

    assign disp_stall = free_cnt_q < CNT_W'(DISP_W);
    assign free_cnt   = free_cnt_q;
    assign disp_ok    = !disp_stall && !flush;

    // CDB compare for resident entries and for the ops dispatching this cycle
    always_comb begin
        wake1  = '0;
        wake2  = '0;
        dwake1 = '0;
        dwake2 = '0;
        for (int k = 0; k < CDB_W; k++) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag1_q[i]) wake1[i] = 1'b1;
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag2_q[i]) wake2[i] = 1'b1;
            end
            for (int l = 0; l < DISP_W; l++) begin
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_tag1[l*TAG_W +: TAG_W]) dwake1[l] = 1'b1;
                if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == disp_tag2[l*TAG_W +: TAG_W]) dwake2[l] = 1'b1;
            end
        end
        elig = valid_q & (rdy1_q | wake1) & (rdy2_q | wake2);
    end

    // Age order among eligible entries: rank = number of eligible entries older than this one
    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            rank[i] = '0;
            for (int j = 0; j < N_ENTRIES; j++)
                rank[i] = rank[i] + CNT_W'(older_q[i][j] & elig[j]);
        end
    end

    always_comb begin
        gnt           = '0;
        issue_valid   = '0;
        issue_class   = '0;
        issue_payload = '0;
        iss_cnt       = '0;
        bud_ok        = 1'b0;
        for (int c = 0; c < N_CLASS; c++) cls_used[c] = '0;
        if (!flush) begin
            for (int p = 0; p < N_ENTRIES; p++) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    if (elig[i] && rank[i] == CNT_W'(p) && iss_cnt < ISS_W'(ISSUE_W)) begin
                        bud_ok = 1'b0;
                        for (int c = 0; c < N_CLASS; c++)
                            if (cls_q[i] == CLS_W'(c) && cls_used[c] < {1'b0, fu_budget[c*BUD_W +: BUD_W]})
                                bud_ok = 1'b1;
                        if (bud_ok) begin
                            gnt[i] = 1'b1;
                            for (int c = 0; c < N_CLASS; c++)
                                if (cls_q[i] == CLS_W'(c)) cls_used[c] = cls_used[c] + 1'b1;
                            for (int k = 0; k < ISSUE_W; k++) begin
                                if (iss_cnt == ISS_W'(k)) begin
                                    issue_valid[k]                          = 1'b1;
                                    issue_class[k*CLS_W +: CLS_W]           = cls_q[i];
                                    issue_payload[k*PAYLOAD_W +: PAYLOAD_W] = pay_q[i];
                                end
                            end
                            iss_cnt = iss_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Lane l takes the l-th lowest free entry; idle lanes consume nothing
    always_comb begin
        taken     = '0;
        alloc_cnt = '0;
        found     = 1'b0;
        for (int l = 0; l < DISP_W; l++) begin
            lane_mask[l] = '0;
            found        = 1'b0;
            if (disp_ok && disp_valid[l]) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    if (!found && !valid_q[i] && !taken[i]) begin
                        found        = 1'b1;
                        taken[i]     = 1'b1;
                        lane_mask[l][i] = 1'b1;
                    end
                end
                alloc_cnt = alloc_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q & ~gnt;
        rdy1_d  = rdy1_q | wake1;
        rdy2_d  = rdy2_q | wake2;
        prior   = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            tag1_d[i]  = tag1_q[i];
            tag2_d[i]  = tag2_q[i];
            cls_d[i]   = cls_q[i];
            pay_d[i]   = pay_q[i];
            older_d[i] = older_q[i] & ~gnt;
        end
        for (int l = 0; l < DISP_W; l++) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (lane_mask[l][i]) begin
                    valid_d[i] = 1'b1;
                    tag1_d[i]  = disp_tag1[l*TAG_W +: TAG_W];
                    tag2_d[i]  = disp_tag2[l*TAG_W +: TAG_W];
                    rdy1_d[i]  = disp_rdy1[l] | dwake1[l];
                    rdy2_d[i]  = disp_rdy2[l] | dwake2[l];
                    cls_d[i]   = disp_class[l*CLS_W +: CLS_W];
                    pay_d[i]   = disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
                    older_d[i] = (valid_q & ~gnt) | prior;
                end
            end
            prior = prior | lane_mask[l];
        end
        free_cnt_d = free_cnt_q - CNT_W'(alloc_cnt) + CNT_W'(iss_cnt);
        if (flush) begin
            valid_d    = '0;
            free_cnt_d = CNT_W'(N_ENTRIES);
            for (int i = 0; i < N_ENTRIES; i++) older_d[i] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q    <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            free_cnt_q <= CNT_W'(N_ENTRIES);
            for (int i = 0; i < N_ENTRIES; i++) older_q[i] <= '0;
        end else begin
            valid_q    <= valid_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            free_cnt_q <= free_cnt_d;
            for (int i = 0; i < N_ENTRIES; i++) older_q[i] <= older_d[i];
        end
    end

    // Payload-side fields are only meaningful while valid, so they carry no reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            tag1_q[i] <= tag1_d[i];
            tag2_q[i] <= tag2_d[i];
            cls_q[i]  <= cls_d[i];
            pay_q[i]  <= pay_d[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset && !flush)
            assert ({1'b0, free_cnt_q} + (CNT_W+1)'(iss_cnt) >= (CNT_W+1)'(alloc_cnt))
                else $error("rs_age_param: free_cnt underflow");
    end
endmodule

// File: tb/tb_rs_age_param.sv
// Directed bench for rs_age_param: scoreboard of expected issues, popped in lane order by a negedge monitor.
module tb_rs_age_param;
    localparam int DW = 3, IW = 3, CW = 3, TW = 6, CLW = 2, PW = 96;

    logic            clock = 1'b0;
    logic            reset, flush;
    logic [DW-1:0]   disp_valid, disp_rdy1, disp_rdy2;
    logic [DW*TW-1:0] disp_tag1, disp_tag2;
    logic [DW*CLW-1:0] disp_class;
    logic [DW*PW-1:0]  disp_payload;
    logic            disp_stall;
    logic [4:0]      free_cnt;
    logic [CW-1:0]   cdb_valid;
    logic [CW*TW-1:0] cdb_tag;
    logic [5:0]      fu_budget;
    logic [IW-1:0]   issue_valid;
    logic [IW*CLW-1:0] issue_class;
    logic [IW*PW-1:0]  issue_payload;

    typedef struct {
        logic [1:0]  cls;
        logic [95:0] pay;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int checks = 0;
    int failures = 0;

    localparam logic [5:0] B_ALL3 = 6'b111111;
    localparam logic [5:0] B_MUL1 = 6'b110111;
    localparam logic [5:0] B_MUL0 = 6'b110011;
    localparam logic [5:0] B_ALU1 = 6'b111101;

    rs_age_param dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
        .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2), .disp_class(disp_class),
        .disp_payload(disp_payload), .disp_stall(disp_stall), .free_cnt(free_cnt),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_budget(fu_budget),
        .issue_valid(issue_valid), .issue_class(issue_class), .issue_payload(issue_payload)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [95:0] mkpay(input int id);
        return {64'hABCD_1234_0000_0000, id};
    endfunction

    task automatic push(input logic [1:0] cls, input int id);
        exp_t x;
        x.cls = cls;
        x.pay = mkpay(id);
        exp_q.push_back(x);
    endtask

    task automatic set_lane(input int l, input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2, input logic [1:0] cls, input int id);
        disp_valid[l]             = 1'b1;
        disp_tag1[l*TW +: TW]     = t1;
        disp_rdy1[l]              = r1;
        disp_tag2[l*TW +: TW]     = t2;
        disp_rdy2[l]              = r2;
        disp_class[l*CLW +: CLW]  = cls;
        disp_payload[l*PW +: PW]  = mkpay(id);
    endtask

    task automatic set_cdb(input int k, input logic [5:0] t);
        cdb_valid[k]          = 1'b1;
        cdb_tag[k*TW +: TW]   = t;
    endtask

    task automatic idle();
        disp_valid = '0;
        cdb_valid  = '0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: every valid lane must match the head of the expected queue
    always @(negedge clock) begin
        if (reset) begin
            chk("issue_packed", 96'((issue_valid & (issue_valid + 3'd1)) == 3'd0), 96'd1);
            for (int k = 0; k < IW; k++) begin
                if (issue_valid[k]) begin
                    chk("issue_expected", 96'(exp_q.size() > 0), 96'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("issue_payload", issue_payload[k*PW +: PW], e.pay);
                        chk("issue_class", 96'(issue_class[k*CLW +: CLW]), 96'(e.cls));
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; fu_budget = B_ALL3;
        disp_valid = '0; disp_rdy1 = '0; disp_rdy2 = '0; disp_tag1 = '0; disp_tag2 = '0;
        disp_class = '0; disp_payload = '0; cdb_valid = '0; cdb_tag = '0;
        next(); next();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_issue_valid", 96'(issue_valid), 96'd0);
        chk("rst_free_cnt", 96'(free_cnt), 96'd16);
        chk("rst_disp_stall", 96'(disp_stall), 96'd0);
        next();

        // Three ready ALU ops: not issued in dispatch cycle, all three next cycle in lane order
        set_lane(0, 6'd1, 1, 6'd2, 1, 2'd0, 1);
        set_lane(1, 6'd1, 1, 6'd2, 1, 2'd0, 2);
        set_lane(2, 6'd1, 1, 6'd2, 1, 2'd0, 3);
        push(2'd0, 1); push(2'd0, 2); push(2'd0, 3);
        @(negedge clock);
        chk("t1_no_issue_disp_cycle", 96'(issue_valid), 96'd0);
        next(); idle();
        @(negedge clock);
        chk("t1_issue_all", 96'(issue_valid), 96'b111);
        chk("t1_free_13", 96'(free_cnt), 96'd13);
        next();
        @(negedge clock);
        chk("t1_free_16", 96'(free_cnt), 96'd16);
        next();

        // Fill to 14 entries, waiting on tags 21 (entry 0) and 20 (rest)
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 3; l++)
                set_lane(l, (c == 0 && l == 0) ? 6'd21 : 6'd20, 0, 6'd3, 1, 2'd0, 100 + 3*c + l);
            next();
        end
        idle();
        set_lane(0, 6'd20, 0, 6'd3, 1, 2'd0, 112);
        set_lane(2, 6'd20, 0, 6'd3, 1, 2'd0, 113);
        next(); idle();
        // Stalled: a ready op offered now must be refused
        set_cdb(0, 6'd21);
        set_lane(0, 6'd1, 1, 6'd1, 1, 2'd0, 99);
        push(2'd0, 100);
        @(negedge clock);
        chk("t2_free_2", 96'(free_cnt), 96'd2);
        chk("t2_stall", 96'(disp_stall), 96'd1);
        chk("t2_issue_one", 96'(issue_valid), 96'b001);
        next(); idle();
        @(negedge clock);
        chk("t2_free_3", 96'(free_cnt), 96'd3);
        chk("t2_stall_clear", 96'(disp_stall), 96'd0);
        chk("t2_refused_no_issue", 96'(issue_valid), 96'd0);
        next();
        set_cdb(1, 6'd20);
        for (int id = 101; id <= 113; id++) push(2'd0, id);
        @(negedge clock);
        next(); idle();
        repeat (4) begin
            @(negedge clock);
            next();
        end
        @(negedge clock);
        chk("t2_drain_free", 96'(free_cnt), 96'd16);
        chk("t2_drain_sb_empty", 96'(exp_q.size()), 96'd0);
        next();

        // Same-cycle CDB capture for dispatching ops, both sources
        set_lane(0, 6'd7, 0, 6'd0, 1, 2'd2, 200);
        set_lane(1, 6'd0, 1, 6'd9, 0, 2'd0, 201);
        set_cdb(0, 6'd7); set_cdb(1, 6'd63); set_cdb(2, 6'd9);
        push(2'd2, 200); push(2'd0, 201);
        @(negedge clock);
        chk("t3_no_issue_disp_cycle", 96'(issue_valid), 96'd0);
        next(); idle();
        @(negedge clock);
        chk("t3_issue_captured", 96'(issue_valid), 96'b011);
        next();

        // Four MULT ops of different ages, MULT budget 1
        fu_budget = B_MUL1;
        for (int l = 0; l < 3; l++) set_lane(l, 6'd1, 1, 6'd1, 1, 2'd1, 300 + l);
        for (int id = 300; id <= 303; id++) push(2'd1, id);
        @(negedge clock);
        chk("t4_disp_cycle", 96'(issue_valid), 96'd0);
        next(); idle();
        set_lane(0, 6'd1, 1, 6'd1, 1, 2'd1, 303);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("t4_one_per_cycle", 96'(issue_valid), 96'b001);
            next(); idle();
        end
        @(negedge clock);
        chk("t4_done", 96'(issue_valid), 96'd0);
        chk("t4_free", 96'(free_cnt), 96'd16);
        next();

        // MULT budget 0 blocks the class until it is raised
        fu_budget = B_MUL0;
        set_lane(0, 6'd1, 1, 6'd1, 1, 2'd1, 310);
        next(); idle();
        repeat (2) begin
            @(negedge clock);
            chk("t4b_budget0_blocks", 96'(issue_valid), 96'd0);
            next();
        end
        fu_budget = B_MUL1;
        push(2'd1, 310);
        @(negedge clock);
        chk("t4b_budget1_issues", 96'(issue_valid), 96'b001);
        next();
        fu_budget = B_ALL3;

        // Entry 9 made older than a re-allocated entry 2
        set_lane(0, 6'd50, 0, 6'd1, 1, 2'd0, 400);
        set_lane(1, 6'd50, 0, 6'd1, 1, 2'd0, 401);
        set_lane(2, 6'd42, 0, 6'd1, 1, 2'd0, 402);
        next();
        for (int c = 1; c < 3; c++) begin
            for (int l = 0; l < 3; l++) set_lane(l, 6'd50, 0, 6'd1, 1, 2'd0, 400 + 3*c + l);
            next();
        end
        idle();
        set_lane(0, 6'd40, 0, 6'd1, 1, 2'd0, 409);
        set_cdb(0, 6'd42);
        push(2'd0, 402);
        next(); idle();
        set_lane(0, 6'd41, 0, 6'd1, 1, 2'd0, 410);
        next(); idle();
        fu_budget = B_ALU1;
        set_cdb(0, 6'd41); set_cdb(1, 6'd40);
        push(2'd0, 409); push(2'd0, 410);
        @(negedge clock);
        chk("t5_age_first", 96'(issue_valid), 96'b001);
        next(); idle();
        @(negedge clock);
        chk("t5_younger_next", 96'(issue_valid), 96'b001);
        next();
        fu_budget = B_ALL3;

        // Flush with eight entries woken by the CDB and two lanes dispatching
        @(negedge clock);
        chk("t6_pre_flush_free", 96'(free_cnt), 96'd8);
        next();
        flush = 1'b1;
        set_cdb(0, 6'd50);
        set_lane(0, 6'd1, 1, 6'd1, 1, 2'd0, 500);
        set_lane(1, 6'd1, 1, 6'd1, 1, 2'd0, 501);
        @(negedge clock);
        chk("t6_flush_no_issue", 96'(issue_valid), 96'd0);
        next(); idle(); flush = 1'b0;
        @(negedge clock);
        chk("t6_free_16", 96'(free_cnt), 96'd16);
        chk("t6_no_issue_after", 96'(issue_valid), 96'd0);
        next();
        set_lane(0, 6'd1, 1, 6'd1, 1, 2'd2, 600);
        push(2'd2, 600);
        next(); idle();
        @(negedge clock);
        chk("t6_post_flush_issue", 96'(issue_valid), 96'b001);
        next();

        // Reset mid-operation discards waiting entries
        for (int l = 0; l < 3; l++) set_lane(l, 6'd60, 0, 6'd1, 1, 2'd0, 700 + l);
        next(); idle();
        reset = 1'b0;
        set_cdb(0, 6'd60);
        set_lane(0, 6'd1, 1, 6'd1, 1, 2'd0, 710);
        next(); idle();
        reset = 1'b1;
        @(negedge clock);
        chk("t7_reset_free", 96'(free_cnt), 96'd16);
        chk("t7_reset_stall", 96'(disp_stall), 96'd0);
        next();
        set_cdb(0, 6'd60);
        @(negedge clock);
        chk("t7_no_stale_issue", 96'(issue_valid), 96'd0);
        next(); idle();

        @(negedge clock);
        chk("sb_final_empty", 96'(exp_q.size()), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
